// File: rtl/ocm_arb_pkg.sv
// Shared types and sizing for the on-chip RAM port arbiter.
// Bit 0 of any two-port vector is port A, bit 1 is port B.
package ocm_arb_pkg;

   localparam int OCM_DEPTH  = 8192;
   localparam int OCM_ADDR_W = 13;

   typedef enum logic {SEL_A, SEL_B} port_sel_e;
   typedef enum logic {CLEAR, RUN}   state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. When both ports request, the grant goes to the
// port that did not win most recently. Bit 0 is port A, bit 1 is port B.
module rr_arb2
   import ocm_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] gnt
);

   port_sel_e last_gnt;

   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         if (req == 2'b11) gnt = (last_gnt == SEL_B) ? 2'b01 : 2'b10;
         else              gnt = req;
      end
   end

   // Reset to B so that A wins the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         last_gnt <= SEL_B;
      else if (gnt[0]) last_gnt <= SEL_A;
      else if (gnt[1]) last_gnt <= SEL_B;
   end

endmodule

// File: rtl/ocm_port_arbiter.sv
// Shares one single-port RAM between port A (pixel DMA) and port B (CPU),
// optionally zero-filling the RAM after reset before anyone is served.
//
// state | meaning
// CLEAR | writing zero to clr_cnt each cycle, busy high, no grants
// RUN   | round-robin arbitration, one access per cycle
module ocm_port_arbiter
   import ocm_arb_pkg::*;
#(
   parameter int ADDR_W         = OCM_ADDR_W,
   parameter int DEPTH          = OCM_DEPTH,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_write,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [3:0]        a_be,
   input  logic [31:0]       a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [31:0]       a_rdata,
   input  logic              b_req,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [3:0]        b_be,
   input  logic [31:0]       b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [31:0]       b_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   input  logic [31:0]       mem_readdata
);

   localparam state_e            RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

   state_e            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        gnt;
   logic              rd_a_q;
   logic              rd_b_q;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (reset),
      .req    ({b_req, a_req}),
      .enable (state == RUN),
      .gnt    (gnt)
   );

   assign a_gnt     = gnt[0];
   assign b_gnt     = gnt[1];
   assign mem_clken = 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RESET_STATE;
         busy    <= (CLEAR_ON_RESET != 0);
         clr_cnt <= '0;
      end else if (state == CLEAR) begin
         if (clr_cnt == LAST_ADDR) begin
            state <= RUN;
            busy  <= 1'b0;
         end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_byteenable = 4'h0;
      mem_writedata  = 32'h0;
      mem_address    = addr_q;
      if (state == CLEAR) begin
         mem_chipselect = 1'b1;
         mem_write      = 1'b1;
         mem_byteenable = 4'hF;
         mem_address    = clr_cnt;
      end else if (gnt[0]) begin
         mem_chipselect = 1'b1;
         mem_write      = a_write;
         mem_byteenable = a_be;
         mem_writedata  = a_wdata;
         mem_address    = a_addr;
      end else if (gnt[1]) begin
         mem_chipselect = 1'b1;
         mem_write      = b_write;
         mem_byteenable = b_be;
         mem_writedata  = b_wdata;
         mem_address    = b_addr;
      end
   end

   // Idle cycles keep presenting the last address to the RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)               addr_q <= '0;
      else if (mem_chipselect) addr_q <= mem_address;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_a_q <= 1'b0;
         rd_b_q <= 1'b0;
      end else begin
         rd_a_q <= gnt[0] & ~a_write;
         rd_b_q <= gnt[1] & ~b_write;
      end
   end

   assign a_rvalid = rd_a_q;
   assign b_rvalid = rd_b_q;
   assign a_rdata  = mem_readdata;
   assign b_rdata  = mem_readdata;

endmodule

// File: tb/tb_ocm_port_arbiter.sv
// Bench for ocm_port_arbiter: RAM model, vector table, hand-written corner
// sequences and a randomized run against a word-level reference memory.
module tb_ocm_port_arbiter;

   localparam int AW    = 13;
   localparam int DEPTH = 8192;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          a_req, a_write, b_req, b_write;
   logic [AW-1:0] a_addr, b_addr;
   logic [3:0]    a_be, b_be;
   logic [31:0]   a_wdata, b_wdata;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
   logic [31:0]   a_rdata, b_rdata;
   logic [AW-1:0] mem_address;
   logic [3:0]    mem_byteenable;
   logic          mem_chipselect, mem_write, mem_clken;
   logic [31:0]   mem_writedata, mem_readdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ocm_port_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .busy(busy),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   // Single-port RAM with registered read, as the real s1 slave behaves.
   logic [31:0] ram [DEPTH];
   logic [31:0] ram_q;
   logic        preload = 1'b0;

   always @(posedge clk) begin
      if (preload)
         for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hDEADBEEF;
      if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            for (int k = 0; k < 4; k++)
               if (mem_byteenable[k]) ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
         end else begin
            ram_q <= ram[mem_address];
         end
      end
   end
   assign mem_readdata = ram_q;

   // Reference: expected RAM contents and the most recent winner (0=A, 1=B).
   logic [31:0] ref_mem [DEPTH];
   int          last_win;

   typedef struct {
      logic ar;
      logic br;
      logic eag;
      logic ebg;
   } vec_t;
   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_a(input logic r, input logic w, input logic [AW-1:0] ad,
                        input logic [3:0] be, input logic [31:0] wd);
      a_req = r; a_write = w; a_addr = ad; a_be = be; a_wdata = wd;
   endtask

   task automatic set_b(input logic r, input logic w, input logic [AW-1:0] ad,
                        input logic [3:0] be, input logic [31:0] wd);
      b_req = r; b_write = w; b_addr = ad; b_be = be; b_wdata = wd;
   endtask

   task automatic ref_write(input logic [AW-1:0] ad, input logic [3:0] be, input logic [31:0] wd);
      for (int k = 0; k < 4; k++)
         if (be[k]) ref_mem[ad][8*k +: 8] = wd[8*k +: 8];
   endtask

   task automatic ref_zero();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      last_win = 1;
   endtask

   // Entered just after reset release; follows the zero-fill cycle by cycle.
   // stop_at >= 0 returns while still clearing, at that clear address.
   task automatic run_clear(input int stop_at);
      int n = 0;
      int bad = 0;
      bit stopped = 1'b0;
      a_req = 1'b1;
      b_req = 1'b1;
      #1;
      while (busy === 1'b1 && n <= DEPTH + 10 && !stopped) begin
         if (mem_address !== AW'(n) || mem_write !== 1'b1 || mem_chipselect !== 1'b1 ||
             mem_writedata !== 32'h0 || mem_byteenable !== 4'hF) bad++;
         if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) bad++;
         if (n == stop_at) stopped = 1'b1;
         else begin
            n++;
            @(negedge clk); #1;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      if (stopped) begin
         chk("clear_partial_seq", bad, 0);
      end else begin
         chk("clear_busy_cycles", n, DEPTH);
         chk("clear_write_seq", bad, 0);
      end
   endtask

   task automatic random_phase(input int cycles);
      bit            ah = 1'b0, bh = 1'b0, earv = 1'b0, ebrv = 1'b0;
      logic          ar = 1'b0, aw = 1'b0, br = 1'b0, bw = 1'b0, ww;
      logic [AW-1:0] aa = '0, ba = '0, wa;
      logic [3:0]    abe = 4'hF, bbe = 4'hF, wbe;
      logic [31:0]   awd = '0, bwd = '0, wwd, ead = '0, ebd = '0;
      int            win;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (!ah) begin
            ar = 1'($urandom_range(0, 1)); aw = 1'($urandom_range(0, 1));
            aa = AW'($urandom_range(0, 15)); abe = 4'($urandom_range(1, 15)); awd = $urandom;
         end
         if (!bh) begin
            br = 1'($urandom_range(0, 1)); bw = 1'($urandom_range(0, 1));
            ba = AW'($urandom_range(0, 15)); bbe = 4'($urandom_range(1, 15)); bwd = $urandom;
         end
         set_a(ar, aw, aa, abe, awd);
         set_b(br, bw, ba, bbe, bwd);
         #1;
         chk("rnd_a_rvalid", a_rvalid, earv);
         if (earv) chk("rnd_a_rdata", a_rdata, ead);
         chk("rnd_b_rvalid", b_rvalid, ebrv);
         if (ebrv) chk("rnd_b_rdata", b_rdata, ebd);
         win = -1;
         if (ar && br)  win = (last_win == 1) ? 0 : 1;
         else if (ar)   win = 0;
         else if (br)   win = 1;
         chk("rnd_a_gnt", a_gnt, win == 0);
         chk("rnd_b_gnt", b_gnt, win == 1);
         chk("rnd_cs", mem_chipselect, win >= 0);
         earv = 1'b0;
         ebrv = 1'b0;
         if (win >= 0) begin
            wa  = (win == 0) ? aa  : ba;
            ww  = (win == 0) ? aw  : bw;
            wbe = (win == 0) ? abe : bbe;
            wwd = (win == 0) ? awd : bwd;
            chk("rnd_addr", mem_address, wa);
            chk("rnd_we", mem_write, ww);
            if (ww) begin
               chk("rnd_wdata", mem_writedata, wwd);
               chk("rnd_be", mem_byteenable, wbe);
               ref_write(wa, wbe, wwd);
            end else if (win == 0) begin
               earv = 1'b1; ead = ref_mem[wa];
            end else begin
               ebrv = 1'b1; ebd = ref_mem[wa];
            end
            last_win = win;
         end else begin
            chk("rnd_idle_we", mem_write, 1'b0);
         end
         ah = ar && (win != 0);
         bh = br && (win != 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0};

      set_a(1'b1, 1'b0, '0, 4'hF, '0);
      set_b(1'b1, 1'b0, '0, 4'hF, '0);
      @(negedge clk) preload = 1'b1;
      @(negedge clk) preload = 1'b0;
      #1;
      chk("rst_a_gnt", a_gnt, 1'b0);
      chk("rst_b_gnt", b_gnt, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_a_rvalid", a_rvalid, 1'b0);
      chk("rst_b_rvalid", b_rvalid, 1'b0);
      chk("rst_clr_addr", mem_address, 0);
      chk("clken", mem_clken, 1'b1);

      @(negedge clk) reset = 1'b0;
      #1;
      run_clear(-1);
      ref_zero();

      // B reads both ends of the cleared RAM
      @(negedge clk) set_b(1'b1, 1'b0, 13'h0000, 4'hF, '0);
      #1;
      chk("rd0_b_gnt", b_gnt, 1'b1);
      chk("rd0_a_gnt", a_gnt, 1'b0);
      chk("rd0_addr", mem_address, 13'h0000);
      @(negedge clk) set_b(1'b1, 1'b0, 13'h1FFF, 4'hF, '0);
      #1;
      chk("rd0_b_rvalid", b_rvalid, 1'b1);
      chk("rd0_b_rdata", b_rdata, 32'h0);
      chk("rd1_addr", mem_address, 13'h1FFF);
      @(negedge clk) set_b(1'b0, 1'b0, '0, 4'hF, '0);
      #1;
      chk("rd1_b_rvalid", b_rvalid, 1'b1);
      chk("rd1_b_rdata", b_rdata, 32'h0);
      chk("rd1_a_rvalid", a_rvalid, 1'b0);
      @(negedge clk) #1;
      chk("rd1_b_rvalid_drop", b_rvalid, 1'b0);

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         set_a(vecs[i].ar, 1'b0, AW'(100 + i), 4'hF, '0);
         set_b(vecs[i].br, 1'b0, AW'(200 + i), 4'hF, '0);
         #1;
         chk($sformatf("vec%0d_a_gnt", i), a_gnt, vecs[i].eag);
         chk($sformatf("vec%0d_b_gnt", i), b_gnt, vecs[i].ebg);
         chk($sformatf("vec%0d_cs", i), mem_chipselect, vecs[i].eag | vecs[i].ebg);
         if (vecs[i].eag | vecs[i].ebg)
            chk($sformatf("vec%0d_addr", i), mem_address, vecs[i].eag ? AW'(100 + i) : AW'(200 + i));
      end

      // byte-enable write by A, then B reads it back the next cycle
      @(negedge clk);
      set_a(1'b1, 1'b1, 13'd5, 4'b0101, 32'h11223344);
      set_b(1'b0, 1'b0, '0, 4'hF, '0);
      #1;
      chk("be_a_gnt", a_gnt, 1'b1);
      chk("be_we", mem_write, 1'b1);
      chk("be_be", mem_byteenable, 4'b0101);
      @(negedge clk);
      set_a(1'b0, 1'b0, '0, 4'hF, '0);
      set_b(1'b1, 1'b0, 13'd5, 4'hF, '0);
      #1;
      chk("be_b_gnt", b_gnt, 1'b1);
      chk("be_no_wvalid", a_rvalid, 1'b0);
      @(negedge clk) set_b(1'b0, 1'b0, '0, 4'hF, '0);
      #1;
      chk("be_b_rvalid", b_rvalid, 1'b1);
      chk("be_a_rvalid", a_rvalid, 1'b0);
      chk("be_rdata", b_rdata, 32'h00220044);
      @(negedge clk) #1;
      chk("be_b_rvalid_drop", b_rvalid, 1'b0);
      ref_mem[5] = 32'h00220044;

      // lone B request three cycles after an A grant
      @(negedge clk) set_a(1'b1, 1'b0, 13'd9, 4'hF, '0);
      #1;
      chk("single_a_gnt", a_gnt, 1'b1);
      @(negedge clk) set_a(1'b0, 1'b0, '0, 4'hF, '0);
      #1;
      chk("single_a_rvalid", a_rvalid, 1'b1);
      chk("single_a_rdata", a_rdata, 32'h0);
      @(negedge clk) #1;
      @(negedge clk) set_b(1'b1, 1'b0, 13'd5, 4'hF, '0);
      #1;
      chk("single_b_gnt", b_gnt, 1'b1);
      chk("single_a_gnt_low", a_gnt, 1'b0);
      @(negedge clk) set_b(1'b0, 1'b0, '0, 4'hF, '0);
      #1;
      chk("single_b_rvalid", b_rvalid, 1'b1);
      chk("single_b_rdata", b_rdata, 32'h00220044);
      chk("single_a_rvalid_low", a_rvalid, 1'b0);

      last_win = 1;
      random_phase(400);
      set_a(1'b0, 1'b0, '0, 4'hF, '0);
      set_b(1'b0, 1'b0, '0, 4'hF, '0);

      // reset during the rvalid cycle of an A read
      @(negedge clk) set_a(1'b1, 1'b0, 13'd5, 4'hF, '0);
      #1;
      chk("rr_a_gnt", a_gnt, 1'b1);
      @(negedge clk) set_a(1'b0, 1'b0, '0, 4'hF, '0);
      #1;
      chk("rr_a_rvalid_pre", a_rvalid, 1'b1);
      reset = 1'b1;
      #1;
      chk("rr_a_rvalid_async", a_rvalid, 1'b0);
      chk("rr_busy", busy, 1'b1);
      preload = 1'b1;
      @(negedge clk) preload = 1'b0;
      reset = 1'b0;
      #1;
      run_clear(100);

      // reset at clear address 100 restarts from zero
      reset = 1'b1;
      #1;
      chk("midclr_addr0", mem_address, 0);
      chk("midclr_busy", busy, 1'b1);
      @(negedge clk) reset = 1'b0;
      #1;
      run_clear(-1);
      ref_zero();

      @(negedge clk) set_b(1'b1, 1'b0, 13'd5, 4'hF, '0);
      #1;
      chk("post_b_gnt", b_gnt, 1'b1);
      chk("post_a_rvalid", a_rvalid, 1'b0);
      @(negedge clk) set_b(1'b0, 1'b0, '0, 4'hF, '0);
      #1;
      chk("post_b_rvalid", b_rvalid, 1'b1);
      chk("post_b_rdata", b_rdata, ref_mem[5]);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
